// File: rtl/mc_sequencer_pkg.sv
// Shared encodings for the multi-cycle instruction sequencer: states,
// decoded instruction classes and PC source selects.
package mc_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EXE  = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5,
    S_ERR  = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    C_ALU    = 3'd0,
    C_LOAD   = 3'd1,
    C_STORE  = 3'd2,
    C_BRANCH = 3'd3,
    C_JUMP   = 3'd4,
    C_JAL    = 3'd5,
    C_HALT   = 3'd6,
    C_ILL    = 3'd7
  } ins_class_t;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'd0,
    PC_BRANCH = 2'd1,
    PC_JUMP   = 2'd2
  } pc_sel_t;

endpackage

// File: rtl/mc_wait_timer.sv
// Memory-ack wait timer shared by the fetch and data-access states.
// expired flags the last permitted wait cycle; TIMEOUT of 0 never expires.
module mc_wait_timer #(
  parameter int TIMEOUT = 16,
  parameter int TO_W    = 5
) (
  input  logic clk,
  input  logic RST,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] cnt;

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = (TIMEOUT != 0) && (cnt == LAST);

endmodule

// File: rtl/mc_sequencer.sv
// Multi-cycle instruction sequencer: owns datapath strobe timing, memory
// handshakes with ack timeout, halt/error states and performance counters.
//
// state | meaning
// IF    | fetch, wait for imem_ack, load IR
// ID    | decode; jumps retire here
// EXE   | execute; branches retire here
// MEM   | data access, wait for dmem_ack; stores retire here
// WB    | register write-back, retire
// HALT  | stopped, exit by reset only
// ERR   | illegal class or ack timeout, exit by reset only
module mc_sequencer
  import mc_sequencer_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 16,
  parameter int TO_W    = 5
) (
  input  logic             clk,
  input  logic             RST,
  input  logic [2:0]       ins_class,
  input  logic             branch_taken,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  output logic [2:0]       state,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_sel,
  output logic             reg_wr,
  output logic             link,
  output logic             halted,
  output logic             err,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  state_t     state_q;
  state_t     nxt;
  ins_class_t cls;
  pc_sel_t    sel;
  logic       wait_clr;
  logic       wait_inc;
  logic       expired;

  assign cls = ins_class_t'(ins_class);

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q <= S_IF;
    end else begin
      state_q <= nxt;
    end
  end

  always_comb begin
    nxt      = state_q;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    ir_write = 1'b0;
    pc_write = 1'b0;
    sel      = PC_SEQ;
    reg_wr   = 1'b0;
    link     = 1'b0;
    wait_inc = 1'b0;
    case (state_q)
      S_IF: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_write = 1'b1;
          nxt      = S_ID;
        end else if (expired) begin
          nxt = S_ERR;
        end else begin
          wait_inc = 1'b1;
        end
      end
      S_ID: begin
        case (cls)
          C_JUMP: begin
            pc_write = 1'b1;
            sel      = PC_JUMP;
            nxt      = S_IF;
          end
          C_JAL: begin
            pc_write = 1'b1;
            sel      = PC_JUMP;
            reg_wr   = 1'b1;
            link     = 1'b1;
            nxt      = S_IF;
          end
          C_HALT:  nxt = S_HALT;
          C_ILL:   nxt = S_ERR;
          default: nxt = S_EXE;
        endcase
      end
      S_EXE: begin
        case (cls)
          C_BRANCH: begin
            pc_write = 1'b1;
            sel      = branch_taken ? PC_BRANCH : PC_SEQ;
            nxt      = S_IF;
          end
          C_ALU:   nxt = S_WB;
          C_LOAD:  nxt = S_MEM;
          C_STORE: nxt = S_MEM;
          // class changed under an instruction in flight
          default: nxt = S_ERR;
        endcase
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (cls == C_STORE);
        if (dmem_ack) begin
          if (cls == C_STORE) begin
            pc_write = 1'b1;
            nxt      = S_IF;
          end else begin
            nxt = S_WB;
          end
        end else if (expired) begin
          nxt = S_ERR;
        end else begin
          wait_inc = 1'b1;
        end
      end
      S_WB: begin
        reg_wr   = 1'b1;
        pc_write = 1'b1;
        nxt      = S_IF;
      end
      S_HALT:  nxt = S_HALT;
      S_ERR:   nxt = S_ERR;
      default: nxt = S_ERR;
    endcase
  end

  // Any state change also covers the ack case, since an ack always advances.
  assign wait_clr = (nxt != state_q);

  mc_wait_timer #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_wait_timer (
    .clk     (clk),
    .RST     (RST),
    .clr     (wait_clr),
    .inc     (wait_inc),
    .expired (expired)
  );

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      if (state_q != S_HALT && state_q != S_ERR) begin
        cycle_cnt <= cycle_cnt + 1'b1;
      end
      if (pc_write) begin
        instret_cnt <= instret_cnt + 1'b1;
      end
    end
  end

  assign state  = state_q;
  assign pc_sel = sel;
  assign halted = (state_q == S_HALT);
  assign err    = (state_q == S_ERR);

endmodule

// File: tb/tb_mc_sequencer.sv
// Self-checking bench for mc_sequencer: directed and randomized instruction
// streams checked cycle by cycle against a per-instruction state-path model.
module tb_mc_sequencer;

  localparam int CNT_W   = 32;
  localparam int TIMEOUT = 16;
  localparam int TO_W    = 5;

  localparam logic [2:0] ST_IF = 3'd0, ST_ID = 3'd1, ST_EXE = 3'd2, ST_MEM = 3'd3,
                         ST_WB = 3'd4, ST_HALT = 3'd5, ST_ERR = 3'd6;
  localparam logic [2:0] CL_ALU = 3'd0, CL_LOAD = 3'd1, CL_STORE = 3'd2, CL_BRANCH = 3'd3,
                         CL_JUMP = 3'd4, CL_JAL = 3'd5, CL_HALT = 3'd6, CL_ILL = 3'd7;

  logic             clk;
  logic             RST;
  logic [2:0]       ins_class;
  logic             branch_taken;
  logic             imem_ack;
  logic             dmem_ack;
  logic [2:0]       state;
  logic             imem_req;
  logic             dmem_req;
  logic             dmem_we;
  logic             ir_write;
  logic             pc_write;
  logic [1:0]       pc_sel;
  logic             reg_wr;
  logic             link;
  logic             halted;
  logic             err;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] instret_cnt;

  int errors = 0;
  int checks = 0;
  logic [CNT_W-1:0] m_cycles;
  logic [CNT_W-1:0] m_instret;

  mc_sequencer #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) dut (
    .clk          (clk),
    .RST          (RST),
    .ins_class    (ins_class),
    .branch_taken (branch_taken),
    .imem_ack     (imem_ack),
    .dmem_ack     (dmem_ack),
    .state        (state),
    .imem_req     (imem_req),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .ir_write     (ir_write),
    .pc_write     (pc_write),
    .pc_sel       (pc_sel),
    .reg_wr       (reg_wr),
    .link         (link),
    .halted       (halted),
    .err          (err),
    .cycle_cnt    (cycle_cnt),
    .instret_cnt  (instret_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    checks++;
    assert (obs === want)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds reset across one rising edge and releases it 1 time unit after an edge.
  task automatic do_reset();
    RST       = 1'b1;
    imem_ack  = 1'b0;
    dmem_ack  = 1'b0;
    #1;
    chk("rst_state", 64'(state), 64'(ST_IF));
    chk("rst_imem_req", 64'(imem_req), 64'd1);
    chk("rst_cycle_cnt", 64'(cycle_cnt), 64'd0);
    chk("rst_instret_cnt", 64'(instret_cnt), 64'd0);
    @(posedge clk);
    #1;
    RST       = 1'b0;
    m_cycles  = '0;
    m_instret = '0;
  endtask

  // One complete instruction: iw fetch wait cycles, dw data wait cycles.
  task automatic run_instr(input logic [2:0] cls, input logic tk, input int iw, input int dw);
    logic [2:0] path[$];
    logic [2:0] st;
    logic [1:0] want_sel;
    logic [8:0] obs;
    logic [8:0] want;
    logic       last;
    int         n_if;
    int         n_mem;
    path  = {};
    n_if  = 0;
    n_mem = 0;
    for (int i = 0; i <= iw; i++) path.push_back(ST_IF);
    path.push_back(ST_ID);
    case (cls)
      CL_ALU:    begin path.push_back(ST_EXE); path.push_back(ST_WB); end
      CL_LOAD: begin
        path.push_back(ST_EXE);
        for (int i = 0; i <= dw; i++) path.push_back(ST_MEM);
        path.push_back(ST_WB);
      end
      CL_STORE: begin
        path.push_back(ST_EXE);
        for (int i = 0; i <= dw; i++) path.push_back(ST_MEM);
      end
      CL_BRANCH: path.push_back(ST_EXE);
      default:   ;
    endcase
    want_sel = (cls == CL_JUMP || cls == CL_JAL) ? 2'd2 :
               (cls == CL_BRANCH && tk)          ? 2'd1 : 2'd0;
    chk("cycle_cnt_start", 64'(cycle_cnt), 64'(m_cycles));
    chk("instret_cnt_start", 64'(instret_cnt), 64'(m_instret));
    ins_class    = cls;
    branch_taken = tk;
    for (int k = 0; k < path.size(); k++) begin
      st       = path[k];
      last     = (k == path.size() - 1);
      imem_ack = (st == ST_IF) && (n_if == iw);
      dmem_ack = (st == ST_MEM) && (n_mem == dw);
      @(negedge clk);
      want = {st, st == ST_IF, st == ST_MEM, imem_ack, last,
              (st == ST_WB) || (st == ST_ID && cls == CL_JAL),
              (st == ST_ID && cls == CL_JAL)};
      obs  = {state, imem_req, dmem_req, ir_write, pc_write, reg_wr, link};
      chk($sformatf("strobes cls=%0d step=%0d", cls, k), 64'(obs), 64'(want));
      if (last) chk($sformatf("pc_sel cls=%0d", cls), 64'(pc_sel), 64'(want_sel));
      if (st == ST_MEM) chk("dmem_we", 64'(dmem_we), 64'(cls == CL_STORE));
      if (st == ST_IF) n_if++;
      if (st == ST_MEM) n_mem++;
      tick();
      m_cycles++;
      if (last) m_instret++;
    end
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
  endtask

  initial begin
    logic [2:0] rc;
    logic       rt;
    int         riw;
    int         rdw;
    RST          = 1'b1;
    ins_class    = CL_ALU;
    branch_taken = 1'b0;
    imem_ack     = 1'b0;
    dmem_ack     = 1'b0;
    m_cycles     = '0;
    m_instret    = '0;
    do_reset();

    // Six basic classes, two idle fetch cycles before the first.
    run_instr(CL_ALU, 1'b0, 2, 0);
    run_instr(CL_LOAD, 1'b0, 0, 0);
    run_instr(CL_STORE, 1'b0, 0, 0);
    run_instr(CL_BRANCH, 1'b1, 0, 0);
    run_instr(CL_JUMP, 1'b0, 0, 0);
    run_instr(CL_JAL, 1'b0, 0, 0);
    chk("six_cycle_cnt", 64'(cycle_cnt), 64'(m_cycles));
    chk("six_instret_cnt", 64'(instret_cnt), 64'(m_instret));

    // Delayed fetch ack, and acks landing in the last permitted wait cycle.
    run_instr(CL_ALU, 1'b0, 5, 0);
    run_instr(CL_LOAD, 1'b0, 0, TIMEOUT - 1);
    run_instr(CL_STORE, 1'b0, TIMEOUT - 1, TIMEOUT - 1);
    run_instr(CL_BRANCH, 1'b0, 1, 0);

    for (int n = 0; n < 40; n++) begin
      rc  = 3'($urandom_range(0, 5));
      rt  = 1'($urandom_range(0, 1));
      riw = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, TIMEOUT - 1)) : int'($urandom_range(0, 2));
      rdw = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, TIMEOUT - 1)) : int'($urandom_range(0, 2));
      run_instr(rc, rt, riw, rdw);
    end

    // Reset asserted in the middle of a data access.
    ins_class = CL_LOAD;
    imem_ack  = 1'b1;
    tick();
    imem_ack = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk("pre_rst_dmem_req", 64'(dmem_req), 64'd1);
    #2;
    RST = 1'b1;
    #1;
    chk("mid_rst_dmem_req", 64'(dmem_req), 64'd0);
    chk("mid_rst_state", 64'(state), 64'(ST_IF));
    @(posedge clk);
    #1;
    RST = 1'b0;
    chk("post_rst_cycle_cnt", 64'(cycle_cnt), 64'd0);
    chk("post_rst_instret_cnt", 64'(instret_cnt), 64'd0);
    m_cycles  = '0;
    m_instret = '0;

    // Data ack never arrives: error after TIMEOUT cycles in MEM.
    ins_class = CL_LOAD;
    imem_ack  = 1'b1;
    tick();
    imem_ack = 1'b0;
    tick();
    tick();
    m_cycles = m_cycles + 3;
    for (int i = 0; i < TIMEOUT; i++) begin
      @(negedge clk);
      chk($sformatf("mem_wait %0d", i), 64'(state), 64'(ST_MEM));
      tick();
      m_cycles++;
    end
    @(negedge clk);
    chk("timeout_state", 64'(state), 64'(ST_ERR));
    chk("timeout_err", 64'(err), 64'd1);
    chk("timeout_dmem_req", 64'(dmem_req), 64'd0);
    chk("timeout_cycle_cnt", 64'(cycle_cnt), 64'(m_cycles));
    repeat (5) tick();
    chk("err_frozen_cycle_cnt", 64'(cycle_cnt), 64'(m_cycles));
    chk("err_frozen_instret_cnt", 64'(instret_cnt), 64'(m_instret));

    // HALT class parks the sequencer.
    do_reset();
    ins_class = CL_HALT;
    imem_ack  = 1'b1;
    tick();
    imem_ack = 1'b0;
    @(negedge clk);
    chk("halt_id_pc_write", 64'(pc_write), 64'd0);
    tick();
    m_cycles = m_cycles + 2;
    chk("halted", 64'(halted), 64'd1);
    chk("halt_state", 64'(state), 64'(ST_HALT));
    chk("halt_imem_req", 64'(imem_req), 64'd0);
    repeat (100) tick();
    chk("halt_cycle_cnt", 64'(cycle_cnt), 64'(m_cycles));
    chk("halt_instret_cnt", 64'(instret_cnt), 64'(m_instret));

    // Illegal class goes to ERR from decode.
    do_reset();
    ins_class = CL_ILL;
    imem_ack  = 1'b1;
    tick();
    imem_ack = 1'b0;
    tick();
    m_cycles = m_cycles + 2;
    chk("illegal_err", 64'(err), 64'd1);
    chk("illegal_state", 64'(state), 64'(ST_ERR));
    chk("illegal_cycle_cnt", 64'(cycle_cnt), 64'(m_cycles));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
